// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared constants, pixel/row types and fetch FSM states for the tile line renderer
package tile_pkg;

    localparam int H_ACTIVE = 640;   // visible pixels per line
    localparam int V_ACTIVE = 480;   // visible lines per frame
    localparam int V_TOTAL  = 525;   // total lines per frame
    localparam int H_FETCH  = 640;   // hcount at which the next-line fetch is issued
    localparam int COLS     = 40;    // tiles per line
    localparam int TILE_W   = 16;    // pixels per tile row
    localparam int PIX_W    = 16;    // bits per pixel

    typedef logic [PIX_W-1:0]        pixel_t;
    typedef logic [TILE_W*PIX_W-1:0] tile_row_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FETCH
    } fetch_state_t;

    // Pixel 0 is the leftmost pixel and sits in the most significant word of the row.
    function automatic pixel_t row_pixel(input tile_row_t row, input logic [3:0] idx);
        return row[(TILE_W - 1 - int'(idx)) * PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/tile_line_buffer.sv
// rtl/tile_line_buffer.sv - ping-pong line buffer, 2 banks x 40 tile rows, one write and one registered read port
//
// Ports:
//   clk      in   pixel clock
//   wr_en    in   write strobe
//   wr_bank  in   bank being filled (address MSB)
//   wr_col   in   tile column written
//   wr_data  in   tile row written
//   rd_en    in   read strobe
//   rd_bank  in   bank being displayed (address MSB)
//   rd_col   in   tile column read
//   rd_data  out  tile row, valid one cycle after rd_en
module tile_line_buffer
    import tile_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic       wr_bank,
    input  logic [5:0] wr_col,
    input  tile_row_t  wr_data,
    input  logic       rd_en,
    input  logic       rd_bank,
    input  logic [5:0] rd_col,
    output tile_row_t  rd_data
);

    tile_row_t mem [2][COLS];

    // Storage is deliberately not reset; contents are undefined until a fetch fills them.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_col) < COLS)) begin
            mem[wr_bank][wr_col] <= wr_data;
        end
        if (rd_en && (int'(rd_col) < COLS)) begin
            rd_data <= mem[rd_bank][rd_col];
        end
    end

endmodule

// File: rtl/tile_line_renderer.sv
// rtl/tile_line_renderer.sv - fetches the next scanline of tile rows and streams the current one as pixels
//
// Ports:
//   clk          in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   hcount       in   current pixel column 0..799
//   vcount       in   current line 0..524
//   map_sel      in   requested tilemap, taken at the frame fetch (line 524)
//   tile_start   out  one-cycle fetch request to the tile engine
//   tilemap_idx  out  tilemap index presented to the tile engine
//   tile_col     in   column carried by tile_data this cycle
//   tile_data    in   tile row, pixel p at bits [255-16p -: 16]
//   tile_done    in   tile engine idle / finished
//   pixel        out  pixel colour, 0 outside the active area
//   pixel_valid  out  pixel belongs to an active-area position
//   fetch_err    out  sticky: a fetch was due while the engine was busy
module tile_line_renderer
    import tile_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic [1:0] map_sel,
    output logic       tile_start,
    output logic [1:0] tilemap_idx,
    input  logic [5:0] tile_col,
    input  tile_row_t  tile_data,
    input  logic       tile_done,
    output pixel_t     pixel,
    output logic       pixel_valid,
    output logic       fetch_err
);

    fetch_state_t state;
    logic         wr_bank;
    logic         first_fetch;
    logic         last_line;
    logic         fetch_due;

    logic         active;
    logic         act_d1;
    logic [3:0]   sel_d1;
    tile_row_t    rd_row;

    assign last_line = (vcount == 10'(V_TOTAL - 1));
    // Lines 479..523 need no fetch: the line after them is not visible (or is refetched at 524).
    assign fetch_due = (hcount == 10'(H_FETCH)) &&
                       ((vcount < 10'(V_ACTIVE - 1)) || last_line);

    // The start pulse must reflect the engine's state in the request cycle itself.
    assign tile_start = (state == REQ) && tile_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_bank     <= 1'b0;
            first_fetch <= 1'b0;
            tilemap_idx <= 2'd0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_due) begin
                        state   <= REQ;
                        // Line 524 prepares line 0, which lives in bank 0.
                        wr_bank <= last_line ? 1'b0 : ~vcount[0];
                        if (last_line) begin
                            tilemap_idx <= map_sel;
                        end
                    end
                end
                REQ: begin
                    if (tile_done) begin
                        state       <= FETCH;
                        first_fetch <= 1'b1;
                    end else begin
                        fetch_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                FETCH: begin
                    first_fetch <= 1'b0;
                    // tile_done right after the start pulse is stale engine status; ignore it.
                    if (!first_fetch && tile_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign active = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));

    tile_line_buffer u_buf (
        .clk     (clk),
        .wr_en   (state == FETCH),
        .wr_bank (wr_bank),
        .wr_col  (tile_col),
        .wr_data (tile_data),
        .rd_en   (active),
        .rd_bank (vcount[0]),
        .rd_col  (hcount[9:4]),
        .rd_data (rd_row)
    );

    // Stage 1 runs alongside the buffer read, stage 2 selects the pixel within the row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_d1      <= 1'b0;
            sel_d1      <= 4'd0;
            pixel_valid <= 1'b0;
            pixel       <= '0;
        end else begin
            act_d1      <= active;
            sel_d1      <= hcount[3:0];
            pixel_valid <= act_d1;
            pixel       <= act_d1 ? row_pixel(rd_row, sel_d1) : '0;
        end
    end

endmodule
